// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter for an 8-way 16-bit word multiplexer. Holds a registered select for
// the whole grant and releases it on end-of-packet, burst limit or requester abandon.
module mux8_rr_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic [7:0] last,
  input  logic       ready,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       valid,
  output logic       busy
);

  localparam int unsigned NREQ = 8;
  localparam int unsigned SW   = 3;
  localparam int unsigned CW   = 8;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_nx;
  logic [SW-1:0]   ptr, ptr_nx, sel_nx, pick, idx;
  logic [NREQ-1:0] gnt_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            found, xfer, hit_limit;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sel   <= '0;
      gnt   <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      sel   <= sel_nx;
      gnt   <= gnt_nx;
      ptr   <= ptr_nx;
      cnt   <= cnt_nx;
    end
  end

  // First requesting index scanning from ptr upward, modulo 8
  always_comb begin
    pick  = ptr;
    found = 1'b0;
    idx   = ptr;
    for (int k = 0; k < int'(NREQ); k++) begin
      idx = ptr + SW'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign xfer      = valid && ready;
  assign hit_limit = (MAX_BURST != 0) && (({1'b0, cnt} + 9'd1) == 9'(MAX_BURST));

  // Next-state logic
  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    gnt_nx   = gnt;
    ptr_nx   = ptr;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        gnt_nx = '0;
        if (found) begin
          sel_nx   = pick;
          gnt_nx   = NREQ'(1) << pick;
          cnt_nx   = '0;
          state_nx = GRANT;
        end
      end
      GRANT: begin
        if (xfer) begin
          cnt_nx = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);
          if (last[sel] || hit_limit) begin
            state_nx = IDLE;
            gnt_nx   = '0;
            ptr_nx   = sel + SW'(1);
          end
        end else if (!req[sel]) begin
          state_nx = IDLE;
          gnt_nx   = '0;
          ptr_nx   = sel + SW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded from registered state and live request
  always_comb begin
    busy  = (state == GRANT);
    valid = busy && req[sel];
  end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: behavioural grant model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mux8_rr_arbiter;

  localparam int MB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req, last;
  logic       ready;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       valid, busy;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: who holds the grant, where the next scan starts, beats in this grant
  bit mbusy = 0;
  int msel = 0, mptr = 0, mcnt = 0, gx = 0, last_gx = 0;
  int glog[$];

  always #5 clk = ~clk;

  mux8_rr_arbiter #(.MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .req(req), .last(last), .ready(ready),
    .sel(sel), .gnt(gnt), .valid(valid), .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic release_grant();
    mbusy   = 0;
    mptr    = (msel + 1) % 8;
    last_gx = gx;
  endtask

  task automatic model_edge();
    if (reset) begin
      mbusy = 0; msel = 0; mptr = 0; mcnt = 0;
    end else if (!mbusy) begin
      for (int k = 0; k < 8; k++) begin
        if (!mbusy && req[(mptr + k) % 8]) begin
          msel  = (mptr + k) % 8;
          mbusy = 1;
          mcnt  = 0;
          gx    = 0;
          glog.push_back(msel);
        end
      end
    end else if (req[msel] && ready) begin
      gx++;
      mcnt = (mcnt < 255) ? mcnt + 1 : 255;
      if (last[msel] || (MB != 0 && mcnt == MB)) release_grant();
    end else if (!req[msel]) begin
      release_grant();
    end
  endtask

  task automatic compare_all();
    chk("sel", 32'(sel), 32'(msel));
    chk("gnt", 32'(gnt), mbusy ? (32'd1 << msel) : 32'd0);
    chk("busy", 32'(busy), 32'(mbusy));
    chk("valid", 32'(valid), 32'(mbusy && req[msel]));
  endtask

  task automatic step(input logic r, input logic [7:0] rq, input logic [7:0] lt, input logic rd);
    reset = r; req = rq; last = lt; ready = rd;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    logic [7:0] rq, lt;
    reset = 1'b1; req = '0; last = '0; ready = 1'b0;

    // Reset with all requesting
    repeat (2) step(1, 8'hFF, 8'h00, 1);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_busy", 32'(busy), 0);
    glog.delete();

    // Round robin, single-beat packets
    step(0, 8'hFF, 8'hFF, 1);
    chk("first_gnt", 32'(gnt), 32'h01);
    repeat (16) step(0, 8'hFF, 8'hFF, 1);
    chk("rr_len", 32'(glog.size()), 9);
    for (int k = 0; k < glog.size() && k < 9; k++) chk("rr_order", 32'(glog[k]), 32'(k % 8));
    step(0, 8'hFF, 8'hFF, 1);
    chk("rr_bubble", 32'(busy), 0);
    step(0, 8'h81, 8'hFF, 1);
    chk("rr_7_first", 32'(sel), 7);
    step(0, 8'h81, 8'hFF, 1);
    step(0, 8'h81, 8'hFF, 1);
    chk("rr_then_0", 32'(sel), 0);
    step(0, 8'h81, 8'hFF, 1);

    // Single 3-beat packet on requester 3
    step(0, 8'h08, 8'h00, 1);
    chk("pkt_gnt", 32'(gnt), 32'h08);
    chk("pkt_sel", 32'(sel), 3);
    step(0, 8'h08, 8'h00, 1);
    step(0, 8'h08, 8'h00, 1);
    step(0, 8'h08, 8'h08, 1);
    chk("pkt_beats", 32'(last_gx), 3);
    chk("pkt_rel", 32'(gnt), 0);
    step(0, 8'h18, 8'h00, 1);
    chk("pkt_ptr4", 32'(sel), 4);
    step(0, 8'h00, 8'h00, 1);

    // Burst limit on requester 5
    step(0, 8'h20, 8'h00, 1);
    chk("bl_sel", 32'(sel), 5);
    repeat (4) step(0, 8'h20, 8'h00, 1);
    chk("bl_beats", 32'(last_gx), 4);
    chk("bl_bubble", 32'(gnt), 0);
    step(0, 8'h20, 8'h00, 1);
    chk("bl_regrant", 32'(gnt), 32'h20);

    // Backpressure then abandon
    step(0, 8'h20, 8'h00, 1);
    repeat (3) begin
      step(0, 8'h20, 8'h00, 0);
      chk("bp_sel", 32'(sel), 5);
      chk("bp_valid", 32'(valid), 1);
    end
    step(0, 8'h00, 8'h00, 1);
    chk("ab_gnt", 32'(gnt), 0);
    chk("ab_beats", 32'(last_gx), 1);
    step(0, 8'h60, 8'h00, 1);
    chk("ab_ptr6", 32'(sel), 6);

    // Reset mid-grant
    repeat (2) step(0, 8'h40, 8'h00, 1);
    step(1, 8'h40, 8'h00, 1);
    chk("mr_gnt", 32'(gnt), 0);
    chk("mr_sel", 32'(sel), 0);
    chk("mr_busy", 32'(busy), 0);
    step(0, 8'h40, 8'h00, 1);
    chk("mr_regrant", 32'(sel), 6);
    repeat (4) step(0, 8'h40, 8'h00, 1);
    chk("mr_cnt_restart", 32'(last_gx), 4);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rq = 8'($urandom) & 8'($urandom);
      if (mbusy && $urandom_range(0, 9) != 0) rq[msel] = 1'b1;
      lt = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      step($urandom_range(0, 199) == 0, rq, lt, $urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
